// File: rtl/l1_cache_wb.sv
// Write-back, write-allocate set-associative L1 data cache with true-LRU replacement.
// A dirty victim is written back to L2 before the refill; hit/miss/writeback counters saturate.
module l1_cache_wb #(
  parameter int DATA_WIDTH      = 32,
  parameter int ADDR_WIDTH      = 32,
  parameter int NUM_SETS        = 16,
  parameter int NUM_WAYS        = 4,
  parameter int WORDS_PER_BLOCK = 4,
  parameter int CNT_WIDTH       = 16
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic                                  cpu_req,
  input  logic                                  cpu_we,
  input  logic [ADDR_WIDTH-1:0]                 cpu_addr,
  input  logic [DATA_WIDTH-1:0]                 cpu_wdata,
  output logic                                  cpu_done,
  output logic [DATA_WIDTH-1:0]                 cpu_rdata,
  output logic                                  cpu_hit,
  output logic                                  l2_req,
  output logic                                  l2_we,
  output logic [ADDR_WIDTH-1:0]                 l2_addr,
  output logic [WORDS_PER_BLOCK*DATA_WIDTH-1:0] l2_wdata,
  input  logic [WORDS_PER_BLOCK*DATA_WIDTH-1:0] l2_rdata,
  input  logic                                  l2_ack,
  output logic [CNT_WIDTH-1:0]                  hit_count,
  output logic [CNT_WIDTH-1:0]                  miss_count,
  output logic [CNT_WIDTH-1:0]                  wb_count
);

  localparam int OFF_W = $clog2(WORDS_PER_BLOCK);
  localparam int IDX_W = $clog2(NUM_SETS);
  localparam int WAY_W = $clog2(NUM_WAYS);
  localparam int TAG_W = ADDR_WIDTH - IDX_W - OFF_W;
  localparam int BLK_W = WORDS_PER_BLOCK * DATA_WIDTH;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_LOOKUP    = 2'd1,
    ST_WRITEBACK = 2'd2,
    ST_REFILL    = 2'd3
  } state_t;

  state_t                  state_r;
  logic                    valid_r [NUM_SETS][NUM_WAYS];
  logic                    dirty_r [NUM_SETS][NUM_WAYS];
  logic [WAY_W-1:0]        age_r   [NUM_SETS][NUM_WAYS];
  logic [TAG_W-1:0]        tag_r   [NUM_SETS][NUM_WAYS];
  logic [DATA_WIDTH-1:0]   data_r  [NUM_SETS][NUM_WAYS][WORDS_PER_BLOCK];

  logic [ADDR_WIDTH-1:0]   addr_r;
  logic                    we_r;
  logic [DATA_WIDTH-1:0]   wdata_r;
  logic [WAY_W-1:0]        victim_r;

  logic [OFF_W-1:0]        off_s;
  logic [IDX_W-1:0]        idx_s;
  logic [TAG_W-1:0]        tag_s;
  logic                    hit_s;
  logic [WAY_W-1:0]        hit_way_s;
  logic                    inv_found_s;
  logic [WAY_W-1:0]        inv_way_s;
  logic [WAY_W-1:0]        lru_way_s;
  logic [WAY_W-1:0]        victim_s;
  logic [BLK_W-1:0]        victim_blk_s;
  logic [DATA_WIDTH-1:0]   refill_words_s [WORDS_PER_BLOCK];
  logic                    ack_s;
  logic                    acc_s;
  logic [WAY_W-1:0]        acc_way_s;

  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
    if (&v) begin
      return v;
    end else begin
      return v + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
    end
  endfunction

  assign off_s = addr_r[OFF_W-1:0];
  assign idx_s = addr_r[OFF_W +: IDX_W];
  assign tag_s = addr_r[ADDR_WIDTH-1 -: TAG_W];
  assign ack_s = l2_req & l2_ack;

  // Tag match, victim choice and victim block assembly for the latched request's set.
  always_comb begin
    hit_s        = 1'b0;
    hit_way_s    = {WAY_W{1'b0}};
    inv_found_s  = 1'b0;
    inv_way_s    = {WAY_W{1'b0}};
    lru_way_s    = {WAY_W{1'b0}};
    victim_blk_s = {BLK_W{1'b0}};
    for (int w = 0; w < NUM_WAYS; w++) begin
      if (valid_r[idx_s][w] && (tag_r[idx_s][w] == tag_s)) begin
        hit_s     = 1'b1;
        hit_way_s = WAY_W'(w);
      end else begin
        hit_s     = hit_s;
      end
      if (age_r[idx_s][w] == WAY_W'(NUM_WAYS - 1)) begin
        lru_way_s = WAY_W'(w);
      end else begin
        lru_way_s = lru_way_s;
      end
    end
    // Descending scan so the lowest-index invalid way wins.
    for (int w = NUM_WAYS - 1; w >= 0; w--) begin
      if (!valid_r[idx_s][w]) begin
        inv_found_s = 1'b1;
        inv_way_s   = WAY_W'(w);
      end else begin
        inv_found_s = inv_found_s;
      end
    end
    if (inv_found_s) begin
      victim_s = inv_way_s;
    end else begin
      victim_s = lru_way_s;
    end
    for (int k = 0; k < WORDS_PER_BLOCK; k++) begin
      victim_blk_s[k*DATA_WIDTH +: DATA_WIDTH] = data_r[idx_s][victim_s][k];
    end
  end

  // Refill block with the store word merged in, plus the way whose LRU age is refreshed.
  always_comb begin
    for (int k = 0; k < WORDS_PER_BLOCK; k++) begin
      if (we_r && (off_s == OFF_W'(k))) begin
        refill_words_s[k] = wdata_r;
      end else begin
        refill_words_s[k] = l2_rdata[k*DATA_WIDTH +: DATA_WIDTH];
      end
    end
    if (state_r == ST_LOOKUP) begin
      acc_s     = hit_s;
      acc_way_s = hit_way_s;
    end else begin
      acc_s     = (state_r == ST_REFILL) && ack_s;
      acc_way_s = victim_r;
    end
  end

  // Control FSM, line metadata, LRU ages, counters and all registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r    <= ST_IDLE;
      cpu_done   <= 1'b0;
      cpu_rdata  <= {DATA_WIDTH{1'b0}};
      cpu_hit    <= 1'b0;
      l2_req     <= 1'b0;
      l2_we      <= 1'b0;
      l2_addr    <= {ADDR_WIDTH{1'b0}};
      l2_wdata   <= {BLK_W{1'b0}};
      hit_count  <= {CNT_WIDTH{1'b0}};
      miss_count <= {CNT_WIDTH{1'b0}};
      wb_count   <= {CNT_WIDTH{1'b0}};
      addr_r     <= {ADDR_WIDTH{1'b0}};
      we_r       <= 1'b0;
      wdata_r    <= {DATA_WIDTH{1'b0}};
      victim_r   <= {WAY_W{1'b0}};
      for (int s = 0; s < NUM_SETS; s++) begin
        for (int w = 0; w < NUM_WAYS; w++) begin
          valid_r[s][w] <= 1'b0;
          dirty_r[s][w] <= 1'b0;
          age_r[s][w]   <= WAY_W'(w);
        end
      end
    end else begin
      cpu_done <= 1'b0;
      cpu_hit  <= 1'b0;
      if (acc_s) begin
        for (int w = 0; w < NUM_WAYS; w++) begin
          if (WAY_W'(w) == acc_way_s) begin
            age_r[idx_s][w] <= {WAY_W{1'b0}};
          end else if (age_r[idx_s][w] < age_r[idx_s][acc_way_s]) begin
            age_r[idx_s][w] <= age_r[idx_s][w] + {{(WAY_W-1){1'b0}}, 1'b1};
          end else begin
            age_r[idx_s][w] <= age_r[idx_s][w];
          end
        end
      end
      case (state_r)
        ST_IDLE: begin
          if (cpu_req && !cpu_done) begin
            addr_r  <= cpu_addr;
            we_r    <= cpu_we;
            wdata_r <= cpu_wdata;
            state_r <= ST_LOOKUP;
          end
        end
        ST_LOOKUP: begin
          if (hit_s) begin
            cpu_done  <= 1'b1;
            cpu_hit   <= 1'b1;
            hit_count <= sat_inc(hit_count);
            if (we_r) begin
              cpu_rdata                  <= wdata_r;
              dirty_r[idx_s][hit_way_s]  <= 1'b1;
            end else begin
              cpu_rdata <= data_r[idx_s][hit_way_s][off_s];
            end
            state_r <= ST_IDLE;
          end else begin
            miss_count <= sat_inc(miss_count);
            victim_r   <= victim_s;
            l2_req     <= 1'b1;
            if (valid_r[idx_s][victim_s] && dirty_r[idx_s][victim_s]) begin
              l2_we    <= 1'b1;
              l2_addr  <= {tag_r[idx_s][victim_s], idx_s, {OFF_W{1'b0}}};
              l2_wdata <= victim_blk_s;
              state_r  <= ST_WRITEBACK;
            end else begin
              l2_we    <= 1'b0;
              l2_addr  <= {tag_s, idx_s, {OFF_W{1'b0}}};
              state_r  <= ST_REFILL;
            end
          end
        end
        ST_WRITEBACK: begin
          if (ack_s) begin
            l2_req                   <= 1'b0;
            dirty_r[idx_s][victim_r] <= 1'b0;
            wb_count                 <= sat_inc(wb_count);
            state_r                  <= ST_REFILL;
          end
        end
        ST_REFILL: begin
          // Entered with l2_req low after a write-back, so the read is issued here.
          if (!l2_req) begin
            l2_req  <= 1'b1;
            l2_we   <= 1'b0;
            l2_addr <= {tag_s, idx_s, {OFF_W{1'b0}}};
          end else if (l2_ack) begin
            l2_req                   <= 1'b0;
            valid_r[idx_s][victim_r] <= 1'b1;
            dirty_r[idx_s][victim_r] <= we_r;
            cpu_done                 <= 1'b1;
            cpu_rdata                <= refill_words_s[off_s];
            state_r                  <= ST_IDLE;
          end
        end
        default: begin
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

  // Tag and data storage; contents are only meaningful where the valid bit is set.
  always_ff @(posedge clk) begin
    if ((state_r == ST_LOOKUP) && hit_s && we_r) begin
      data_r[idx_s][hit_way_s][off_s] <= wdata_r;
    end
    if ((state_r == ST_REFILL) && ack_s) begin
      tag_r[idx_s][victim_r] <= tag_s;
      for (int k = 0; k < WORDS_PER_BLOCK; k++) begin
        data_r[idx_s][victim_r][k] <= refill_words_s[k];
      end
    end
  end

endmodule

// File: tb/tb_l1_cache_wb.sv
// Directed bench for l1_cache_wb: a hand-driven L2 responder and immediate-assertion checks
// against hand-computed values for the default geometry.
module tb_l1_cache_wb;

  logic         clk;
  logic         rst;
  logic         cpu_req;
  logic         cpu_we;
  logic [31:0]  cpu_addr;
  logic [31:0]  cpu_wdata;
  logic         cpu_done;
  logic [31:0]  cpu_rdata;
  logic         cpu_hit;
  logic         l2_req;
  logic         l2_we;
  logic [31:0]  l2_addr;
  logic [127:0] l2_wdata;
  logic [127:0] l2_rdata;
  logic         l2_ack;
  logic [15:0]  hit_count;
  logic [15:0]  miss_count;
  logic [15:0]  wb_count;

  int tests = 0;
  int fails = 0;

  bit          obs_done, obs_hit, obs_wb_seen, obs_rf_seen, obs_gap, obs_stable;
  int          obs_lat;
  logic [31:0] obs_rdata, obs_wb_addr, obs_wb_w0, obs_wb_w1, obs_rf_addr;

  l1_cache_wb dut (
    .clk(clk), .rst(rst),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_done(cpu_done), .cpu_rdata(cpu_rdata), .cpu_hit(cpu_hit),
    .l2_req(l2_req), .l2_we(l2_we), .l2_addr(l2_addr), .l2_wdata(l2_wdata),
    .l2_rdata(l2_rdata), .l2_ack(l2_ack),
    .hit_count(hit_count), .miss_count(miss_count), .wb_count(wb_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [127:0] blk(input logic [31:0] a);
    logic [127:0] b;
    for (int k = 0; k < 4; k++) b[k*32 +: 32] = 32'h1000_0000 | (a + 32'(k));
    return b;
  endfunction

  // One CPU access; services L2 traffic, acking each transaction after `hold` waiting cycles.
  task automatic access(input logic [31:0] a, input logic we, input logic [31:0] wd,
                        input logic [127:0] rblk, input int hold);
    bit          in_txn;
    int          waited;
    logic [31:0] t_addr;
    logic        t_we;
    obs_done = 0; obs_hit = 0; obs_wb_seen = 0; obs_rf_seen = 0; obs_gap = 0;
    obs_stable = 1; obs_lat = 0; obs_rdata = 32'h0;
    in_txn = 0; waited = 0; t_addr = 32'h0; t_we = 1'b0;
    @(negedge clk);
    cpu_req = 1'b1; cpu_we = we; cpu_addr = a; cpu_wdata = wd;
    for (int cyc = 1; cyc <= 200 && !obs_done; cyc++) begin
      @(negedge clk);
      if (l2_ack) begin
        l2_ack = 1'b0;
        in_txn = 0;
      end
      if (cpu_done) begin
        obs_done = 1; obs_lat = cyc; obs_rdata = cpu_rdata; obs_hit = cpu_hit;
      end else if (l2_req) begin
        if (!in_txn) begin
          in_txn = 1; waited = 0; t_addr = l2_addr; t_we = l2_we;
          if (l2_we) begin
            obs_wb_seen = 1; obs_wb_addr = l2_addr;
            obs_wb_w0 = l2_wdata[31:0]; obs_wb_w1 = l2_wdata[63:32];
          end else begin
            obs_rf_seen = 1; obs_rf_addr = l2_addr;
          end
        end else if (l2_addr !== t_addr || l2_we !== t_we) begin
          obs_stable = 0;
        end
        if (waited >= hold) begin
          l2_ack = 1'b1; l2_rdata = rblk;
        end else begin
          waited++;
        end
      end else if (in_txn) begin
        obs_stable = 0;
      end else if (obs_wb_seen) begin
        obs_gap = 1;
      end
    end
    cpu_req = 1'b0;
    chk("access_done", obs_done, 1'b1);
  endtask

  initial begin
    rst = 1'b0; cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = 32'h0; cpu_wdata = 32'h0;
    l2_ack = 1'b0; l2_rdata = 128'h0;
    #2 rst = 1'b1;
    #1;
    chk("rst_done", cpu_done, 1'b0);
    chk("rst_rdata", cpu_rdata, 32'h0);
    chk("rst_l2_req", l2_req, 1'b0);
    chk("rst_l2_addr", l2_addr, 32'h0);
    chk("rst_hits", hit_count, 16'h0);
    chk("rst_misses", miss_count, 16'h0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Cold read, then hits on the same line
    access(32'h40, 1'b0, 32'h0, {32'h44, 32'h33, 32'h22, 32'h11}, 0);
    chk("cold_rf_seen", obs_rf_seen, 1'b1);
    chk("cold_rf_addr", obs_rf_addr, 32'h40);
    chk("cold_no_wb", obs_wb_seen, 1'b0);
    chk("cold_rdata", obs_rdata, 32'h11);
    chk("cold_hit", obs_hit, 1'b0);
    chk("cold_misses", miss_count, 16'd1);
    access(32'h41, 1'b0, 32'h0, 128'h0, 0);
    chk("hit_lat", obs_lat, 2);
    chk("hit_rdata", obs_rdata, 32'h22);
    chk("hit_flag", obs_hit, 1'b1);
    chk("hit_no_l2", obs_rf_seen, 1'b0);
    chk("hit_count1", hit_count, 16'd1);
    access(32'h42, 1'b1, 32'hDEAD, 128'h0, 0);
    chk("wr_hit", obs_hit, 1'b1);
    chk("wr_rdata", obs_rdata, 32'hDEAD);
    access(32'h42, 1'b0, 32'h0, 128'h0, 0);
    chk("rd_after_wr", obs_rdata, 32'hDEAD);
    chk("hit_count3", hit_count, 16'd3);

    // Reset while a refill is outstanding
    @(negedge clk);
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h80;
    for (int i = 0; i < 20 && !l2_req; i++) @(negedge clk);
    chk("pre_rst_req", l2_req, 1'b1);
    cpu_req = 1'b0;
    rst = 1'b1;
    #1;
    chk("midrst_l2_req", l2_req, 1'b0);
    chk("midrst_done", cpu_done, 1'b0);
    chk("midrst_hits", hit_count, 16'h0);
    chk("midrst_misses", miss_count, 16'h0);
    chk("midrst_wbs", wb_count, 16'h0);
    @(negedge clk);
    rst = 1'b0;
    access(32'h40, 1'b0, 32'h0, {32'h44, 32'h33, 32'h22, 32'h11}, 0);
    chk("post_rst_miss", obs_hit, 1'b0);
    chk("post_rst_rf", obs_rf_addr, 32'h40);
    chk("post_rst_rdata", obs_rdata, 32'h11);

    // Fill set 0; the 0x0C0 refill is held off for 10 cycles
    access(32'h000, 1'b0, 32'h0, blk(32'h000), 0);
    chk("fill0_rdata", obs_rdata, 32'h1000_0000);
    access(32'h040, 1'b0, 32'h0, 128'h0, 0);
    chk("fill40_hit", obs_hit, 1'b1);
    access(32'h080, 1'b0, 32'h0, blk(32'h080), 0);
    chk("fill80_rdata", obs_rdata, 32'h1000_0080);
    access(32'h0C0, 1'b0, 32'h0, blk(32'h0C0), 10);
    chk("hold_stable", obs_stable, 1'b1);
    chk("hold_rf_addr", obs_rf_addr, 32'hC0);
    chk("hold_lat", obs_lat, 13);
    chk("hold_rdata", obs_rdata, 32'h1000_00C0);
    access(32'h000, 1'b0, 32'h0, 128'h0, 0);
    chk("reread0_hit", obs_hit, 1'b1);
    access(32'h100, 1'b0, 32'h0, blk(32'h100), 0);
    chk("evict_clean_no_wb", obs_wb_seen, 1'b0);
    chk("evict_rf_addr", obs_rf_addr, 32'h100);
    access(32'h000, 1'b0, 32'h0, 128'h0, 0);
    chk("keep0_hit", obs_hit, 1'b1);
    chk("keep0_lat", obs_lat, 2);

    // Dirty line at 0x000 forced out by four other set-0 tags
    access(32'h000, 1'b1, 32'h5A, 128'h0, 0);
    chk("wr0_hit", obs_hit, 1'b1);
    access(32'h040, 1'b0, 32'h0, blk(32'h040), 0);
    chk("evicted40_miss", obs_hit, 1'b0);
    chk("evicted40_rdata", obs_rdata, 32'h1000_0040);
    access(32'h141, 1'b1, 32'hBEEF, blk(32'h140), 0);
    chk("wrmiss_rdata", obs_rdata, 32'hBEEF);
    chk("wrmiss_no_wb", obs_wb_seen, 1'b0);
    access(32'h180, 1'b0, 32'h0, blk(32'h180), 0);
    chk("miss180_no_wb", obs_wb_seen, 1'b0);
    access(32'h1C0, 1'b0, 32'h0, blk(32'h1C0), 0);
    chk("wb_seen", obs_wb_seen, 1'b1);
    chk("wb_addr", obs_wb_addr, 32'h000);
    chk("wb_word0", obs_wb_w0, 32'h5A);
    chk("wb_word1", obs_wb_w1, 32'h1000_0001);
    chk("wb_gap", obs_gap, 1'b1);
    chk("wb_then_rf", obs_rf_addr, 32'h1C0);
    chk("wb_rdata", obs_rdata, 32'h1000_01C0);
    chk("wb_count", wb_count, 16'd1);
    chk("final_misses", miss_count, 16'd9);
    chk("final_hits", hit_count, 16'd4);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/l1_cache_wb.md
Name: l1_cache_wb

Overview:
- Parametrised set-associative L1 data cache. It sits between the CPU load/store port and the L2 cache.
- Write-back, write-allocate, with per-line dirty bits and true-LRU replacement. A victim is written back to L2 before the refill.
- Block-wide L2 transfers use a req/ack handshake. Saturating hit, miss and writeback counters provide performance visibility.

Parameters:
- DATA_WIDTH, 32: CPU word width in bits.
- ADDR_WIDTH, 32: word address width.
- NUM_SETS, 16: number of sets. Power of two, at least 2.
- NUM_WAYS, 4: associativity. Power of two, at least 2.
- WORDS_PER_BLOCK, 4: words per line. Power of two, at least 2.
- CNT_WIDTH, 16: width of each statistics counter.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- cpu_req  in  1  request valid. Held high until cpu_done.
- cpu_we  in  1  1 = write, 0 = read. Sampled with cpu_req.
- cpu_addr  in  ADDR_WIDTH  word address: {tag, index, offset}.
- cpu_wdata  in  DATA_WIDTH  write data.
- cpu_done  out  1  one-cycle completion pulse.
- cpu_rdata  out  DATA_WIDTH  read data, valid while cpu_done is high.
- cpu_hit  out  1  high with cpu_done when the access hit.
- l2_req  out  1  L2 transaction request.
- l2_we  out  1  1 = block write-back, 0 = block read.
- l2_addr  out  ADDR_WIDTH  block-aligned word address (offset = 0).
- l2_wdata  out  WORDS_PER_BLOCK*DATA_WIDTH  victim block. Word 0 is in the LSBs.
- l2_rdata  in  WORDS_PER_BLOCK*DATA_WIDTH  refill block. Word 0 is in the LSBs.
- l2_ack  in  1  L2 completion. l2_rdata is valid in the same cycle.
- hit_count  out  CNT_WIDTH  saturating hit counter.
- miss_count  out  CNT_WIDTH  saturating miss counter.
- wb_count  out  CNT_WIDTH  saturating writeback counter.

Behaviour:
Reset (asynchronous, immediate):
- All outputs go to 0.
- All valid and dirty bits are cleared.
- LRU age of way w is set to w.
- Counters are cleared and the FSM goes to IDLE.
- A reset mid-transaction abandons it: l2_req drops at once and dirty data is lost.

Address fields:
- offset = cpu_addr[log2(WPB)-1:0], where WPB = WORDS_PER_BLOCK.
- index = the next log2(NUM_SETS) bits.
- tag = the remaining upper bits.

FSM states: IDLE, LOOKUP, WRITEBACK, REFILL.

IDLE:
- If cpu_req=1 and cpu_done=0, latch addr, we and wdata, then go to LOOKUP.
- A request is never accepted in the cycle cpu_done is high.

LOOKUP, hit (valid and tag match in some way):
- Read: cpu_rdata <= stored word.
- Write: store cpu_wdata into the word, set dirty, cpu_rdata <= cpu_wdata.
- Registered outputs: cpu_done=1, cpu_hit=1. Update LRU. hit_count+1. Go to IDLE.
- Hit latency: cpu_done is high in the 2nd cycle after the request-accept edge.

LOOKUP, miss:
- miss_count+1.
- Victim = lowest-index invalid way. If all ways are valid, victim = the way with age NUM_WAYS-1.
- Victim dirty: go to WRITEBACK. Otherwise go to REFILL.

WRITEBACK:
- Drive l2_req=1, l2_we=1, l2_addr={victim_tag,index,0}, l2_wdata=victim block.
- On l2_ack: clear the dirty bit, wb_count+1, go to REFILL.
- l2_req is low for at least one cycle before the refill request.

REFILL:
- Drive l2_req=1, l2_we=0, l2_addr={tag,index,0}.
- On l2_ack:
  - Install l2_rdata into the victim way; set valid and tag.
  - Write: merge cpu_wdata into the offset word and set dirty=1.
  - cpu_rdata = the requested word after the merge.
  - cpu_done=1, cpu_hit=0. Update LRU. Go to IDLE.

L2 handshake:
- l2_req, l2_we, l2_addr and l2_wdata are registered and stay stable until l2_ack is sampled high.
- l2_req is deasserted on the edge that samples l2_ack.
- l2_ack while l2_req=0 is ignored.
- There is no timeout; the cache waits indefinitely.

LRU:
- Each way has a log2(NUM_WAYS)-bit age.
- On access to way w, every way with age < age[w] increments, then age[w] = 0.
- Ages remain a permutation of 0..NUM_WAYS-1 at all times.

Counters:
- Each counter saturates at 2^CNT_WIDTH-1 and never wraps.
- A dirty miss increments both miss_count and wb_count.

Requester:
- Must hold cpu_req and its fields stable until cpu_done.
- Must deassert cpu_req or present a new request after the cpu_done cycle.

Test Plan:
Test values use the defaults, so offset = addr[1:0], index = addr[5:2], tag = addr[31:6].
- Cold read of 0x40 -> l2_req with l2_we=0 and l2_addr=0x40. Ack with rdata words {0x11,0x22,0x33,0x44} -> cpu_rdata=0x11, cpu_hit=0, miss_count=1. Then read 0x41 -> cpu_done 2 cycles after accept, cpu_rdata=0x22, cpu_hit=1, no l2_req, hit_count=1.
- Write 0x42 with 0xDEAD after the fill -> hit, cpu_rdata=0xDEAD. Then read 0x42 -> 0xDEAD.
- Fill set 0 with reads of 0x000, 0x040, 0x080 and 0x0C0. Re-read 0x000, then read 0x100 -> the 0x040 line is evicted (no write-back, clean). A following read of 0x000 hits.
- Write 0x000 with 0x5A, then miss on 4 other set-0 tags -> WRITEBACK to l2_addr=0x000 with word0=0x5A before the refill read; wb_count=1; l2_req is low for at least one cycle between the two transactions.
- Hold l2_ack low for 10 cycles during REFILL -> l2_req, l2_addr and l2_we stay constant and cpu_done stays 0. The ack completes the access normally.
- Assert rst during REFILL -> l2_req=0 and cpu_done=0 immediately, counters are 0. Re-reading the previously cached 0x40 misses.
